// File: rtl/neural_wb_bridge_if.sv
// Wishbone-classic bus bundle for the neural bridge.
// Master drives the request, slave returns ack/data.
interface neural_wb_bridge_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_sel_i, wb_adr_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_sel_i, wb_adr_i, wb_dat_i,
    output wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/neural_wb_bridge.sv
// Wishbone slave splitting 64-bit neural locations into 32-bit words.
// Staged atomic writes on the high half, snapshot tear-free reads.
module neural_wb_bridge #(
  parameter int          NUM_WIDTH = 64,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          NN_ADDR_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  neural_wb_bridge_if.slave    wb,
  output logic [NN_ADDR_W-1:0] nn_addr,
  output logic [NUM_WIDTH-1:0] nn_data_in,
  output logic                 nn_we,
  input  logic [NUM_WIDTH-1:0] nn_data_out
);

  localparam int HW = NUM_WIDTH / 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_ACK
  } state_t;

  state_t               r_state;
  logic                 r_ack;
  logic [31:0]          r_dat;
  logic [NN_ADDR_W-1:0] r_addr;
  logic [NUM_WIDTH-1:0] r_data_in;
  logic                 r_we;
  logic [HW-1:0]        r_stage_lo;
  logic [HW-1:0]        r_stage_hi;
  logic [NUM_WIDTH-1:0] r_snap;
  logic [NN_ADDR_W-1:0] r_snap_addr;
  logic                 r_snap_valid;
  logic                 r_rd_hi;

  logic                 w_req;
  logic                 w_hit;
  logic                 w_hi;
  logic [NN_ADDR_W-1:0] w_loc;
  logic [HW-1:0]        w_old;
  logic [HW-1:0]        w_merge;
  logic                 w_snap_hit;
  logic                 w_unused;

  assign w_req  = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_hit  = wb.wb_adr_i[31:27] == BASE_ADDR[31:27];
  assign w_hi   = wb.wb_adr_i[2];
  assign w_loc  = wb.wb_adr_i[3 +: NN_ADDR_W];
  assign w_old  = w_hi ? r_stage_hi : r_stage_lo;
  assign w_snap_hit = r_snap_valid && (r_snap_addr == w_loc);
  assign w_unused   = &{1'b0, wb.wb_adr_i[1:0]};

  // Byte-lane merge of bus write data over the selected staging half
  always_comb begin
    w_merge = w_old;
    for (int b = 0; b < 4; b++) begin
      if (wb.wb_sel_i[b]) begin
        w_merge[8*b +: 8] = wb.wb_dat_i[8*b +: 8];
      end
    end
  end

  // Transaction FSM with all bus and neural outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ack        <= 1'b0;
      r_dat        <= '0;
      r_addr       <= '0;
      r_data_in    <= '0;
      r_we         <= 1'b0;
      r_stage_lo   <= '0;
      r_stage_hi   <= '0;
      r_snap       <= '0;
      r_snap_addr  <= '0;
      r_snap_valid <= 1'b0;
      r_rd_hi      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ack <= 1'b0;
          if (w_req) begin
            if (!w_hit) begin
              r_ack   <= 1'b1;
              r_state <= S_ACK;
              if (!wb.wb_we_i) begin
                r_dat <= '0;
              end
            end else if (wb.wb_we_i) begin
              r_snap_valid <= 1'b0;
              r_ack        <= 1'b1;
              r_state      <= S_ACK;
              if (w_hi) begin
                r_stage_hi <= w_merge;
                r_addr     <= w_loc;
                r_data_in  <= {w_merge, r_stage_lo};
                r_we       <= 1'b1;
              end else begin
                r_stage_lo <= w_merge;
              end
            end else if (w_hi && w_snap_hit) begin
              r_dat        <= r_snap[NUM_WIDTH-1:HW];
              r_snap_valid <= 1'b0;
              r_ack        <= 1'b1;
              r_state      <= S_ACK;
            end else begin
              r_addr  <= w_loc;
              r_rd_hi <= w_hi;
              r_state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          r_state <= wb.wb_cyc_i ? S_CAPTURE : S_IDLE;
        end
        S_CAPTURE: begin
          if (!wb.wb_cyc_i) begin
            r_state <= S_IDLE;
          end else begin
            r_ack   <= 1'b1;
            r_state <= S_ACK;
            if (r_rd_hi) begin
              r_dat        <= nn_data_out[NUM_WIDTH-1:HW];
              r_snap_valid <= 1'b0;
            end else begin
              r_dat        <= nn_data_out[HW-1:0];
              r_snap       <= nn_data_out;
              r_snap_addr  <= r_addr;
              r_snap_valid <= 1'b1;
            end
          end
        end
        S_ACK: begin
          r_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_dat_o = r_dat;
  assign nn_addr     = r_addr;
  assign nn_data_in  = r_data_in;
  assign nn_we       = r_we;

endmodule
